// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Multi-cycle issue controller for the 8-bit datapath ALU. Accepts
//            9-bit instruction words over valid/ready, reads operands from an
//            internal register file, drives the ALU, and writes the result
//            back. The ALU equality flag is reported as a one-cycle EqHit
//            pulse for compare ops.
// Options  : ALU_SEQ_BYPASS_EN - drop the READ state; operands are captured
//            on the transfer edge (3-cycle issue instead of 4).
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
   parameter int W   = 8,
   parameter int Ops = 2,
   parameter int RA  = 3
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              InstrValid,
   output logic              InstrReady,
   input  logic [Ops+2*RA:0] Instr,
   output logic [W-1:0]      AluA,
   output logic [W-1:0]      AluB,
   output logic [W-1:0]      AluC,
   output logic [Ops-1:0]    AluOP,
   input  logic [W-1:0]      AluOut,
   input  logic              AluEq,
   output logic              Done,
   output logic              EqHit,
   input  logic [RA-1:0]     DbgAddr,
   output logic [W-1:0]      DbgData
);

   localparam int             c_nregs  = 1 << RA;
   // Opcode whose equality result is forwarded as a branch event.
   localparam logic [Ops-1:0] c_op_cmp = Ops'(2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            w_xfer;

   // Instruction word fields; bit 0 is reserved and carries no meaning.
   logic [Ops-1:0]  w_f_op;
   logic [RA-1:0]   w_f_rd;
   logic [RA-1:0]   w_f_rs;
   logic            w_unused_rsvd;

   // Register file and per-instruction pipeline state.
   logic [W-1:0]    r_regs [0:c_nregs-1];
   logic [RA-1:0]   r_rd;
`ifndef ALU_SEQ_BYPASS_EN
   logic [RA-1:0]   r_rs;
   logic [Ops-1:0]  r_op;
`endif
   logic [W-1:0]    r_opa;
   logic [W-1:0]    r_opb;
   logic [W-1:0]    r_opc;
   logic [Ops-1:0]  r_aluop;
   logic [W-1:0]    r_res;
   logic            r_eq;

   assign w_f_op        = Instr[Ops+2*RA : 2*RA+1];
   assign w_f_rd        = Instr[2*RA : RA+1];
   assign w_f_rs        = Instr[RA : 1];
   assign w_unused_rsvd = Instr[0];

   // The ALU always sees the operand registers, so its inputs stay stable
   // from EXEC until the next operand capture.
   assign AluA    = r_opa;
   assign AluB    = r_opb;
   assign AluC    = r_opc;
   assign AluOP   = r_aluop;
   assign DbgData = r_regs[DbgAddr];

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and handshake/event outputs, all derived from state.
   always_comb begin
      w_state_next = r_state;
      InstrReady   = 1'b0;
      w_xfer       = 1'b0;
      Done         = 1'b0;
      EqHit        = 1'b0;
      case (r_state)
         S_IDLE: begin
            InstrReady = 1'b1;
            w_xfer     = InstrValid;
            if (InstrValid) begin
`ifdef ALU_SEQ_BYPASS_EN
               w_state_next = S_EXEC;
`else
               w_state_next = S_READ;
`endif
            end
         end
         S_READ: begin
            w_state_next = S_EXEC;
         end
         S_EXEC: begin
            w_state_next = S_WB;
         end
         S_WB: begin
            Done         = 1'b1;
            EqHit        = (r_aluop == c_op_cmp) && r_eq;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Instruction latch and operand capture. All reads see the register file
   // before this instruction's writeback, so rd==rs and rd==0 alias safely.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_rd    <= '0;
`ifndef ALU_SEQ_BYPASS_EN
         r_rs    <= '0;
         r_op    <= '0;
`endif
         r_opa   <= '0;
         r_opb   <= '0;
         r_opc   <= '0;
         r_aluop <= '0;
      end else begin
`ifdef ALU_SEQ_BYPASS_EN
         if (w_xfer) begin
            r_rd    <= w_f_rd;
            r_opa   <= r_regs[w_f_rd];
            r_opb   <= r_regs[w_f_rs];
            r_opc   <= r_regs[0];
            r_aluop <= w_f_op;
         end
`else
         if (w_xfer) begin
            r_rd <= w_f_rd;
            r_rs <= w_f_rs;
            r_op <= w_f_op;
         end
         if (r_state == S_READ) begin
            r_opa   <= r_regs[r_rd];
            r_opb   <= r_regs[r_rs];
            r_opc   <= r_regs[0];
            r_aluop <= r_op;
         end
`endif
      end
   end

   // ALU result capture; the result is taken as-is, modulo 2^W.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_res <= '0;
         r_eq  <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_res <= AluOut;
         r_eq  <= AluEq;
      end
   end

   // Register file: cleared on reset, written once per instruction in WB.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < c_nregs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (r_state == S_WB) begin
         r_regs[r_rd] <= r_res;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer. A behavioural ALU sits on
//            the ALU ports; a force hook lets it return arbitrary values so
//            registers can be preloaded through ordinary instructions.
// Options  : ALU_SEQ_BYPASS_EN - expect the shortened 3-cycle issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

`ifdef ALU_SEQ_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic       clk;
   logic       Reset_n;
   logic       InstrValid;
   logic       InstrReady;
   logic [8:0] Instr;
   logic [7:0] AluA, AluB, AluC;
   logic [1:0] AluOP;
   logic [7:0] AluOut;
   logic       AluEq;
   logic       Done;
   logic       EqHit;
   logic [2:0] DbgAddr;
   logic [7:0] DbgData;

   logic       alu_force;
   logic [7:0] alu_force_val;

   int checks = 0;
   int errors = 0;

   alu_sequencer #(.W(8), .Ops(2), .RA(3)) dut (
      .Clk        (clk),
      .Reset_n    (Reset_n),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Instr      (Instr),
      .AluA       (AluA),
      .AluB       (AluB),
      .AluC       (AluC),
      .AluOP      (AluOP),
      .AluOut     (AluOut),
      .AluEq      (AluEq),
      .Done       (Done),
      .EqHit      (EqHit),
      .DbgAddr    (DbgAddr),
      .DbgData    (DbgData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: add, shift right, shift left (compare), xor-insert.
   always_comb begin
      if (alu_force) begin
         AluOut = alu_force_val;
      end else begin
         case (AluOP)
            2'b00:   AluOut = AluA + AluB;
            2'b01:   AluOut = AluA >> AluB[2:0];
            2'b10:   AluOut = AluA << AluB[2:0];
            default: AluOut = {AluA[6:0], ^AluB};
         endcase
      end
   end
   assign AluEq = (AluA == AluC);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Issue one instruction from an IDLE negedge; returns the Done cycle
   // (relative to the transfer edge, -1 if none) and what the ALU saw in EXEC.
   task automatic run_instr(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            output int dcyc, output logic eqh, output logic busy_rdy,
                            output logic [7:0] ea, output logic [7:0] eb, output logic [7:0] ec);
      dcyc = -1; eqh = 1'b0; busy_rdy = 1'b1;
      ea = 8'h00; eb = 8'h00; ec = 8'h00;
      Instr      = {op, rd, rs, 1'b0};
      InstrValid = 1'b1;
      @(posedge clk);
      #1;
      InstrValid = 1'b0;
      Instr      = 9'h1FF;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) busy_rdy = InstrReady;
         if (k == LAT - 1) begin
            ea = AluA; eb = AluB; ec = AluC;
         end
         if (Done && dcyc < 0) begin
            dcyc = k;
            eqh  = EqHit;
         end
         if (dcyc >= 0 && k == dcyc + 1) break;
      end
   endtask

   // Preload a register by forcing the ALU result of an add rd,rd.
   task automatic load(input logic [2:0] rd, input logic [7:0] val);
      int dc; logic eh, br; logic [7:0] a, b, c;
      alu_force     = 1'b1;
      alu_force_val = val;
      DbgAddr       = rd;
      run_instr(2'b00, rd, rd, dc, eh, br, a, b, c);
      alu_force     = 1'b0;
      chk($sformatf("load_r%0d_done", rd), dc, LAT);
      chk($sformatf("load_r%0d_val", rd), DbgData, val);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [2:0] rd;
      logic [2:0] rs;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] res;
      logic       eq;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int dc; logic eh, br; logic [7:0] a, b, c;
      int acc_cyc [3];
      int done_cyc [3];
      int n_acc, n_done;
      logic acc;

      // op, rd, rs, AluA, AluB, AluC, R[rd] after, EqHit
      vecs[0] = '{2'b00, 3'd1, 3'd1, 8'h03, 8'h03, 8'h05, 8'h06, 1'b0}; // rd==rs
      vecs[1] = '{2'b00, 3'd2, 3'd3, 8'hF0, 8'h20, 8'h05, 8'h10, 1'b0}; // wrap
      vecs[2] = '{2'b10, 3'd4, 3'd5, 8'h05, 8'h01, 8'h05, 8'h0A, 1'b1}; // hit
      vecs[3] = '{2'b10, 3'd4, 3'd5, 8'h0A, 8'h01, 8'h05, 8'h14, 1'b0}; // miss
      vecs[4] = '{2'b01, 3'd7, 3'd5, 8'h80, 8'h01, 8'h05, 8'h40, 1'b0};
      vecs[5] = '{2'b11, 3'd0, 3'd6, 8'h05, 8'h11, 8'h05, 8'h0A, 1'b0}; // eq, op!=10
      vecs[6] = '{2'b10, 3'd6, 3'd1, 8'h11, 8'h06, 8'h0A, 8'h40, 1'b0}; // new R0

      Reset_n = 1'b0; InstrValid = 1'b0; Instr = 9'h000; DbgAddr = 3'd0;
      alu_force = 1'b0; alu_force_val = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", InstrReady, 1'b1);
      chk("rst_done",  Done,       1'b0);
      chk("rst_eqhit", EqHit,      1'b0);
      chk("rst_alua",  AluA,       8'h00);
      chk("rst_alub",  AluB,       8'h00);
      chk("rst_aluc",  AluC,       8'h00);
      chk("rst_aluop", AluOP,      2'b00);
      for (int i = 0; i < 8; i++) begin
         DbgAddr = 3'(i);
         #1;
         chk($sformatf("rst_dbg%0d", i), DbgData, 8'h00);
      end
      Reset_n = 1'b1;

      load(3'd1, 8'h03);
      load(3'd2, 8'hF0);
      load(3'd3, 8'h20);
      load(3'd0, 8'h05);
      load(3'd4, 8'h05);
      load(3'd5, 8'h01);
      load(3'd6, 8'h11);
      load(3'd7, 8'h80);

      // Table of single instructions
      for (int i = 0; i < 7; i++) begin
         DbgAddr = vecs[i].rd;
         run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs, dc, eh, br, a, b, c);
         chk($sformatf("v%0d_done_cycle", i), dc, LAT);
         chk($sformatf("v%0d_busy_ready", i), br, 1'b0);
         chk($sformatf("v%0d_eqhit", i), eh, vecs[i].eq);
         chk($sformatf("v%0d_alua", i), a, vecs[i].a);
         chk($sformatf("v%0d_alub", i), b, vecs[i].b);
         chk($sformatf("v%0d_aluc", i), c, vecs[i].c);
         chk($sformatf("v%0d_result", i), DbgData, vecs[i].res);
      end
      // Registers now: R0=0A R1=06 R2=10 R3=20 R4=14 R5=01 R6=40 R7=40

      // Back-to-back with InstrValid held high
      n_acc = 0; n_done = 0;
      Instr = {2'b00, 3'd1, 3'd1, 1'b0};
      InstrValid = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         acc = InstrValid && InstrReady;
         @(posedge clk);
         #1;
         if (acc) begin
            if (n_acc < 3) acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 1)      Instr = {2'b00, 3'd1, 3'd2, 1'b0};
            else if (n_acc == 2) Instr = {2'b00, 3'd3, 3'd1, 1'b0};
            else                 InstrValid = 1'b0;
         end
         @(negedge clk);
         if (Done) begin
            if (n_done < 3) done_cyc[n_done] = cyc + 1;
            n_done++;
         end
      end
      chk("b2b_accepts", n_acc, 3);
      chk("b2b_dones", n_done, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b_acc%0d_cycle", i), (n_acc > i) ? acc_cyc[i] : -1, i * (LAT + 1));
         chk($sformatf("b2b_done%0d_cycle", i), (n_done > i) ? done_cyc[i] : -1, i * (LAT + 1) + LAT);
      end
      DbgAddr = 3'd1;
      #1;
      chk("b2b_r1", DbgData, 8'h1C);
      DbgAddr = 3'd3;
      #1;
      chk("b2b_r3", DbgData, 8'h3C);

      // Reset while the instruction is in EXEC
      @(negedge clk);
      Instr = {2'b00, 3'd6, 3'd6, 1'b0};
      InstrValid = 1'b1;
      @(posedge clk);
      #1;
      InstrValid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      chk("midrst_exec_alua", AluA, 8'h40);
      Reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_done", Done, 1'b0);
      chk("midrst_ready", InstrReady, 1'b1);
      chk("midrst_alua", AluA, 8'h00);
      Reset_n = 1'b1;
      n_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (Done) n_done++;
      end
      chk("midrst_no_done", n_done, 0);
      DbgAddr = 3'd6;
      #1;
      chk("midrst_r6", DbgData, 8'h00);
      DbgAddr = 3'd1;
      #1;
      chk("midrst_r1", DbgData, 8'h00);

      // rd==rs==0 aliasing: all operands read the old R0
      load(3'd0, 8'h07);
      DbgAddr = 3'd0;
      run_instr(2'b00, 3'd0, 3'd0, dc, eh, br, a, b, c);
      chk("alias_done_cycle", dc, LAT);
      chk("alias_alua", a, 8'h07);
      chk("alias_alub", b, 8'h07);
      chk("alias_aluc", c, 8'h07);
      chk("alias_eqhit", eh, 1'b0);
      chk("alias_r0", DbgData, 8'h0E);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller that feeds the 8-bit datapath ALU. It accepts 9-bit instruction words over a valid/ready handshake and holds an internal 8-entry register file. For each instruction it reads operands, drives the ALU's A/B/C/OP inputs, captures the result and writes it back. It also reports the ALU equality flag as a one-cycle event, so fetch logic can branch on it.

## Interface
Parameters:
- W, 8, data width of registers and ALU operands
- Ops, 2, ALU opcode width
- RA, 3, register address width (2^RA registers)

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset; sampled on rising edge of Clk
- InstrValid  in  1  instruction word present
- InstrReady  out  1  sequencer can accept an instruction this cycle
- Instr  in  9  [8:7]=op, [6:4]=rd, [3:1]=rs, [0]=reserved (ignored)
- AluA  out  W  ALU operand A
- AluB  out  W  ALU operand B
- AluC  out  W  ALU compare operand
- AluOP  out  Ops  ALU opcode
- AluOut  in  W  ALU result
- AluEq  in  1  ALU isEqual flag
- Done  out  1  one-cycle pulse on writeback
- EqHit  out  1  one-cycle pulse, coincident with Done, when the executed op was 2'b10 and AluEq was 1
- DbgAddr  in  RA  debug register-file read address
- DbgData  out  W  combinational contents of R[DbgAddr]

## Operation
- Register file R[0..7], W bits each, is internal. R[0] is an ordinary writable register.
- Operand mapping:
  - AluA = R[rd]
  - AluB = R[rs]
  - AluC = R[0]
  - AluOP = op
  - Result is written to R[rd].
- Op meaning is owned by the ALU: 00 add, 01 shift right, 10 shift left with compare, 11 reduction-XOR insert.
- The sequencer does not interpret op except when qualifying EqHit (op==2'b10).
- FSM states:
  - IDLE: InstrReady=1. On InstrValid, latch Instr and go to READ.
  - READ: latch R[rd], R[rs] and R[0] into operand registers; go to EXEC.
  - EXEC: AluA/B/C/OP driven from operand registers; sample AluOut and AluEq into result registers; go to WB.
  - WB: write result to R[rd]; assert Done, and EqHit if qualified; go to IDLE.
- AluA/B/C/OP are driven from operand registers in every state, not only EXEC. They are stable from the start of EXEC until the next READ.
- Arithmetic is modulo 2^W. No carry or overflow is reported; the ALU result is taken as-is.
- If rd==rs, both operands read the same pre-instruction value.
- If rd==0, AluC also reads the pre-instruction R[0]; the write lands after.
- DbgData reflects the register file after the WB edge, i.e. new values are visible the cycle after Done.

## Timing
- Handshake:
  - Transfer occurs on a rising edge with InstrValid & InstrReady.
  - InstrReady is asserted only in IDLE, is combinational from state, and does not depend on InstrValid.
  - Instr is ignored when no transfer occurs.
- Latency, default build:
  - Transfer edge at cycle 0.
  - READ in cycle 1, EXEC in cycle 2, WB/Done in cycle 3.
  - IDLE again in cycle 4; next transfer no earlier than the cycle-4 edge.
  - Throughput is 1 instruction per 4 cycles.
- Reset, while Reset_n=0 at an edge:
  - State goes to IDLE; all registers, operand and result registers are cleared to 0.
  - Outputs: Done=0, EqHit=0, AluA/B/C=0, AluOP=0, InstrReady=1 starting the cycle after the reset edge.
- Reset mid-instruction: the instruction is abandoned; no writeback and no Done pulse.
- If InstrValid is held high continuously, a new instruction is accepted every 4 cycles. No instruction is lost or duplicated.

## Configuration
- ALU_SEQ_BYPASS_EN defined:
  - READ state is removed; operands are latched from the register file on the transfer edge itself.
  - Transfer at cycle 0, EXEC in cycle 1, WB/Done in cycle 2, IDLE in cycle 3.
  - Throughput is 1 instruction per 3 cycles.
- Not defined: the four-state FSM above.
- In both builds, the register-read-before-write semantics for rd==rs and rd==0 are identical.

## Test plan
- Reset then add: hold Reset_n=0 for 2 cycles and check every output and DbgData (all addresses) =0. Preload via add chain R1=1: R1=R1+R0 with R0 forced by test hook is not available, so instead apply op=00 rd=1 rs=1 after writing R1=3 through a prior sequence. Required: Done exactly at cycle 3 (cycle 2 with BYPASS), DbgData[1]=6.
- Wrap-around: with R2=0xF0 and R3=0x20, apply op=00 rd=2 rs=3 -> R2=0x10, EqHit=0.
- Compare/branch: with R0=0x05, R4=0x05, R5=0x01, apply op=10 rd=4 rs=5 -> AluA=0x05, AluC=0x05, EqHit=1 with Done, and R4 = ALU result. With R4≠R0 -> EqHit=0.
- Back-to-back: hold InstrValid=1 with 3 distinct instructions -> accepts exactly at cycles 0, 4, 8 (0, 3, 6 with BYPASS), three Done pulses, results in order.
- Reset mid-op: assert Reset_n=0 during EXEC of op=00 rd=6 -> no Done; R6=0; InstrReady=1 the cycle after reset.
- Aliasing: with R0=0x07, apply op=00 rd=0 rs=0 -> R0=0x0E, and AluC driven 0x07 during EXEC.
